// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg: shared types and elaboration helpers for the SPI burst memory.
// Holds the FSM state encoding, the sample-edge polarity rule and the
// command word width rule, all evaluated at elaboration time.
package spi_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } state_e;

    // Data is sampled on the rising sclk edge when CPOL and CPHA agree,
    // otherwise on the falling edge; the shift edge is always the other one.
    function automatic bit sample_on_rise(input int cpol, input int cpha);
        return (cpol == cpha);
    endfunction

    // Command word is {addr, rw}.
    function automatic int cmd_width(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: multi-flop synchroniser for one asynchronous SPI pin.
// Produces the synchronised level plus one-clk rise/fall pulses; level and
// pulses appear SYNC_STAGES+1 clk after the pin changes.
module spi_pin_sync
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic                   level_q;
    logic                   rise_q;
    logic                   fall_q;

    // Synchroniser chain followed by a registered edge detector.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            chain_q <= {SYNC_STAGES{RST_VAL}};
            level_q <= RST_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], pin_i};
            level_q <= chain_q[SYNC_STAGES-1];
            rise_q  <= chain_q[SYNC_STAGES-1] & ~level_q;
            fall_q  <= ~chain_q[SYNC_STAGES-1] & level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/spi_mem_burst.sv
// spi_mem_burst: SPI slave memory with burst read/write, address
// auto-increment with wrap at DEPTH, and all four SPI modes.
// Optional macro SPI_MEM_WP_EN adds the wp_n write-protect input and the
// saturating wp_drop_count output.
module spi_mem_burst
    import spi_mem_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 128,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sclk_pin,
    input  logic       cs_pin,
    input  logic       mosi_pin,
`ifdef SPI_MEM_WP_EN
    input  logic       wp_n,
    output logic [7:0] wp_drop_count,
`endif
    output logic       miso_pin,
    output logic       miso_oe,
    output logic       busy,
    output logic [3:0] leds
);

    localparam int   CMD_W       = cmd_width(ADDR_W);
    localparam bit   SAMPLE_RISE = sample_on_rise(CPOL, CPHA);
    localparam int   CNT_W       = $clog2(max_int(CMD_W, DATA_W) + 1);
    localparam logic SCLK_IDLE   = (CPOL != 0);

    // Pin order: [0]=sclk, [1]=cs, [2]=mosi, [3]=wp_n (when present).
    // cs resets to the asserted level so that a cs already low when reset
    // releases is not mistaken for a fresh falling edge.
`ifdef SPI_MEM_WP_EN
    localparam int             NPIN    = 4;
    localparam logic [NPIN-1:0] PIN_RST = {1'b1, 1'b0, 1'b0, SCLK_IDLE};
`else
    localparam int             NPIN    = 3;
    localparam logic [NPIN-1:0] PIN_RST = {1'b0, 1'b0, SCLK_IDLE};
`endif

    logic [NPIN-1:0] pin_raw;
    logic [NPIN-1:0] pin_lvl;
    logic [NPIN-1:0] pin_rise;
    logic [NPIN-1:0] pin_fall;

`ifdef SPI_MEM_WP_EN
    assign pin_raw = {wp_n, mosi_pin, cs_pin, sclk_pin};
`else
    assign pin_raw = {mosi_pin, cs_pin, sclk_pin};
`endif

    for (genvar gi = 0; gi < NPIN; gi++) begin : g_sync
        spi_pin_sync #(
            .SYNC_STAGES (SYNC_STAGES),
            .RST_VAL     (PIN_RST[gi])
        ) u_sync (
            .clk     (clk),
            .reset_n (reset_n),
            .pin_i   (pin_raw[gi]),
            .level_o (pin_lvl[gi]),
            .rise_o  (pin_rise[gi]),
            .fall_o  (pin_fall[gi])
        );
    end

    logic sample_p;
    logic shift_p;
    logic cs_fall;
    logic cs_rise;
    logic mosi_lvl;

    assign sample_p = SAMPLE_RISE ? pin_rise[0] : pin_fall[0];
    assign shift_p  = SAMPLE_RISE ? pin_fall[0] : pin_rise[0];
    assign cs_fall  = pin_fall[1];
    assign cs_rise  = pin_rise[1];
    assign mosi_lvl = pin_lvl[2];

    logic unused_pins;
`ifdef SPI_MEM_WP_EN
    assign unused_pins = &{pin_lvl[1:0], pin_rise[3:2], pin_fall[3:2]};
`else
    assign unused_pins = &{pin_lvl[1:0], pin_rise[2], pin_fall[2]};
`endif

    // Address arithmetic: aliasing into [0, DEPTH) and wrapping increment.
    function automatic logic [ADDR_W-1:0] addr_fold(input logic [ADDR_W-1:0] a);
        return ADDR_W'(32'(a) % DEPTH);
    endfunction

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        if (32'(a) >= DEPTH - 1) begin
            return '0;
        end
        return a + ADDR_W'(1);
    endfunction

    state_e              state_q,      state_d;
    logic [CNT_W-1:0]    bit_cnt_q,    bit_cnt_d;
    logic [CMD_W-2:0]    cmd_q,        cmd_d;       // command bits before the last
    logic [DATA_W-2:0]   rx_q,         rx_d;        // data bits before the last
    logic [DATA_W-1:0]   tx_q,         tx_d;
    logic                miso_q,       miso_d;
    logic [ADDR_W-1:0]   addr_q,       addr_d;
    logic                load_q,       load_d;
    logic                last_rw_q,    last_rw_d;
    logic                write_seen_q, write_seen_d;
`ifdef SPI_MEM_WP_EN
    logic [7:0]          drop_q,       drop_d;
`endif

    logic [CMD_W-1:0]    cmd_shift;
    logic [DATA_W-1:0]   rx_shift;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   rd_data_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    // Memory: one write port driven by the FSM and a registered read that
    // follows the next-state address, so a new READ address has its data
    // one clk later.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= mem_wdata;
        end
        rd_data_q <= mem[addr_d];
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            cmd_q        <= '0;
            rx_q         <= '0;
            tx_q         <= '0;
            miso_q       <= 1'b0;
            addr_q       <= '0;
            load_q       <= 1'b0;
            last_rw_q    <= 1'b0;
            write_seen_q <= 1'b0;
`ifdef SPI_MEM_WP_EN
            drop_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            cmd_q        <= cmd_d;
            rx_q         <= rx_d;
            tx_q         <= tx_d;
            miso_q       <= miso_d;
            addr_q       <= addr_d;
            load_q       <= load_d;
            last_rw_q    <= last_rw_d;
            write_seen_q <= write_seen_d;
`ifdef SPI_MEM_WP_EN
            drop_q       <= drop_d;
`endif
        end
    end

    // Next-state logic: command decode, burst read shifting, burst write
    // assembly, and the cs-rise abort that overrides everything else.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        cmd_d        = cmd_q;
        rx_d         = rx_q;
        tx_d         = tx_q;
        miso_d       = miso_q;
        addr_d       = addr_q;
        load_d       = 1'b0;
        last_rw_d    = last_rw_q;
        write_seen_d = write_seen_q;
        mem_we       = 1'b0;
        mem_wdata    = '0;
        cmd_shift    = {cmd_q, mosi_lvl};
        rx_shift     = {rx_q, mosi_lvl};
`ifdef SPI_MEM_WP_EN
        drop_d       = drop_q;
`endif

        if (load_q) begin
            tx_d = rd_data_q;
        end

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = CMD;
                    bit_cnt_d = '0;
                    cmd_d     = '0;
                    rx_d      = '0;
                end
            end
            CMD: begin
                if (sample_p) begin
                    cmd_d = cmd_shift[CMD_W-2:0];
                    if (bit_cnt_q == CNT_W'(CMD_W - 1)) begin
                        bit_cnt_d = '0;
                        addr_d    = addr_fold(cmd_shift[CMD_W-1:1]);
                        last_rw_d = cmd_shift[0];
                        if (cmd_shift[0]) begin
                            state_d = READ;
                            load_d  = 1'b1;
                        end else begin
                            state_d = WRITE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            READ: begin
                if (shift_p) begin
                    miso_d = tx_q[DATA_W-1];
                    tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        bit_cnt_d = '0;
                        addr_d    = addr_inc(addr_q);
                        load_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            WRITE: begin
                if (sample_p) begin
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        bit_cnt_d = '0;
                        rx_d      = '0;
                        addr_d    = addr_inc(addr_q);
                        mem_wdata = rx_shift;
`ifdef SPI_MEM_WP_EN
                        if (pin_lvl[3]) begin
                            mem_we       = 1'b1;
                            write_seen_d = 1'b1;
                        end else if (drop_q != 8'hFF) begin
                            drop_d = drop_q + 8'd1;
                        end
`else
                        mem_we       = 1'b1;
                        write_seen_d = 1'b1;
`endif
                    end else begin
                        rx_d      = rx_shift[DATA_W-2:0];
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cs_rise && (state_q != IDLE)) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            rx_d      = '0;
            cmd_d     = '0;
            load_d    = 1'b0;
        end
    end

    assign miso_oe  = (state_q == READ);
    assign miso_pin = miso_oe ? miso_q : 1'bz;
    assign busy     = (state_q != IDLE);
    assign leds     = {state_q, last_rw_q, write_seen_q};
`ifdef SPI_MEM_WP_EN
    assign wp_drop_count = drop_q;
`endif

endmodule

// File: tb/tb_spi_mem_burst.sv
// tb_spi_mem_burst: four DUT instances, one per SPI mode, driven by a
// bit-level SPI master and checked against a plain array memory model.
`timescale 1ns/1ps
module tb_spi_mem_burst;

    localparam int HALF = 80;   // sclk half period in ns (8 clk)
    localparam int NM   = 4;    // mode index m = {CPOL, CPHA}

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic         sclk [NM];
    logic         cs   [NM];
    logic         mosi;
    wire [NM-1:0] miso_w;
    wire [NM-1:0] oe_w;
    wire [NM-1:0] busy_w;
    wire [3:0]    leds_w [NM];
`ifdef SPI_MEM_WP_EN
    logic         wp_n;
    wire [7:0]    drop_w [NM];
`endif

    for (genvar gi = 0; gi < NM; gi++) begin : g_dut
        spi_mem_burst #(
            .ADDR_W(7), .DATA_W(8), .DEPTH(128),
            .CPOL(gi / 2), .CPHA(gi % 2), .SYNC_STAGES(2)
        ) u_dut (
            .clk           (clk),
            .reset_n       (reset_n),
            .sclk_pin      (sclk[gi]),
            .cs_pin        (cs[gi]),
            .mosi_pin      (mosi),
`ifdef SPI_MEM_WP_EN
            .wp_n          (wp_n),
            .wp_drop_count (drop_w[gi]),
`endif
            .miso_pin      (miso_w[gi]),
            .miso_oe       (oe_w[gi]),
            .busy          (busy_w[gi]),
            .leds          (leds_w[gi])
        );
    end

    // Reference model: plain memory per instance plus a "written" flag.
    logic [7:0]  ref_mem   [NM][128];
    bit          ref_known [NM][128];
    logic        wp_lvl;
    int          ref_drop;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Shift n bits MSB first; CPHA selects whether the master samples on
    // the leading or the trailing edge of each bit.
    task automatic spi_bits(input int m, input int n, input logic [15:0] out, output logic [15:0] got);
        got = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if ((m % 2) == 0) begin
                mosi = out[i];
                #HALF;
                sclk[m] = ~sclk[m];
                got[i]  = miso_w[m];
                #HALF;
                sclk[m] = ~sclk[m];
            end else begin
                sclk[m] = ~sclk[m];
                mosi    = out[i];
                #HALF;
                sclk[m] = ~sclk[m];
                got[i]  = miso_w[m];
                #HALF;
            end
        end
    endtask

    task automatic cs_low(input int m);
        cs[m] = 1'b0;
        #HALF;
    endtask

    task automatic cs_high(input int m);
        #HALF;
        cs[m] = 1'b1;
        #(2 * HALF);
    endtask

    task automatic do_write(input int m, input int addr, input logic [7:0] d [$]);
        logic [15:0] g;
        $display("write mode=%0d addr=%02h words=%0d wp=%0d", m, addr, d.size(), wp_lvl);
        cs_low(m);
        spi_bits(m, 8, {8'h00, 7'(addr), 1'b0}, g);
        foreach (d[i]) begin
            spi_bits(m, 8, {8'h00, d[i]}, g);
            if (wp_lvl) begin
                ref_mem[m][(addr + i) % 128]   = d[i];
                ref_known[m][(addr + i) % 128] = 1'b1;
            end else if (ref_drop < 255) begin
                ref_drop++;
            end
        end
        cs_high(m);
    endtask

    task automatic do_read(input int m, input int addr, input int n, input string tag);
        logic [15:0] g;
        int a;
        $display("read  mode=%0d addr=%02h words=%0d (%s)", m, addr, n, tag);
        cs_low(m);
        check($sformatf("%s/busy_cmd", tag), 32'(busy_w[m]), 32'd1);
        check($sformatf("%s/oe_cmd", tag), 32'(oe_w[m]), 32'd0);
        spi_bits(m, 8, {8'h00, 7'(addr), 1'b1}, g);
        check($sformatf("%s/oe_read", tag), 32'(oe_w[m]), 32'd1);
        for (int i = 0; i < n; i++) begin
            spi_bits(m, 8, 16'h0000, g);
            a = (addr + i) % 128;
            if (ref_known[m][a]) begin
                check($sformatf("%s/word%0d", tag, i), 32'(g[7:0]), 32'(ref_mem[m][a]));
            end
        end
        cs_high(m);
        check($sformatf("%s/oe_after_cs", tag), 32'(oe_w[m]), 32'd0);
        check($sformatf("%s/busy_after_cs", tag), 32'(busy_w[m]), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  q [$];
        logic [15:0] g;
        int          addr;
        int          n;
        logic [7:0]  keep6;

        reset_n  = 1'b0;
        mosi     = 1'b0;
        wp_lvl   = 1'b1;
        ref_drop = 0;
`ifdef SPI_MEM_WP_EN
        wp_n     = 1'b1;
`endif
        for (int m = 0; m < NM; m++) begin
            sclk[m] = 1'(m / 2);
            cs[m]   = 1'b1;
        end
        repeat (4) @(negedge clk);

        // Reset state of every instance.
        for (int m = 0; m < NM; m++) begin
            check($sformatf("rst%0d/oe", m), 32'(oe_w[m]), 32'd0);
            check($sformatf("rst%0d/busy", m), 32'(busy_w[m]), 32'd0);
            check($sformatf("rst%0d/leds", m), 32'(leds_w[m]), 32'd0);
`ifdef SPI_MEM_WP_EN
            check($sformatf("rst%0d/drop", m), 32'(drop_w[m]), 32'd0);
`endif
        end
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        // Directed write/read burst in every mode, then randomized bursts.
        for (int m = 0; m < NM; m++) begin
            q = {8'hA5, 8'h3C};
            do_write(m, 'h10, q);
            do_read(m, 'h10, 2, $sformatf("mode%0d", m));
            check($sformatf("mode%0d/leds_rw_ws", m), 32'(leds_w[m][1:0]), 32'd3);
            for (int k = 0; k < 2; k++) begin
                addr = $urandom_range(0, 127);
                n    = $urandom_range(1, 3);
                q    = {};
                for (int i = 0; i < n; i++) q.push_back(8'($urandom));
                do_write(m, addr, q);
                do_read(m, addr, n, $sformatf("rand%0d_%0d", m, k));
            end
        end

        // Wrap from the last address back to 0.
        q = {8'h11, 8'h22, 8'h33};
        do_write(0, 'h7F, q);
        do_read(0, 'h7F, 3, "wrap");
        do_read(0, 'h00, 2, "wrap_low");

        // Abort mid-word: the partial word must not reach memory.
        keep6 = 8'($urandom);
        q = {8'($urandom), keep6};
        do_write(0, 'h05, q);
        $display("abort mode=0 addr=05 one word + 5 bits");
        cs_low(0);
        spi_bits(0, 8, 16'h000A, g);
        spi_bits(0, 8, 16'h00FF, g);
        ref_mem[0][5] = 8'hFF;
        spi_bits(0, 5, 16'h0000, g);
        #HALF;
        cs[0] = 1'b1;
        #30;
        check("abort/busy_before_sync", 32'(busy_w[0]), 32'd1);
        #10;
        check("abort/state_idle", 32'(leds_w[0][3:2]), 32'd0);
        #(2 * HALF);
        do_read(0, 'h05, 2, "abort");

        // Reset pulse in the middle of a read word.
        $display("read  mode=0 addr=10 interrupted by reset");
        cs_low(0);
        spi_bits(0, 8, 16'h0021, g);
        spi_bits(0, 3, 16'h0000, g);
        check("rstmid/oe_before", 32'(oe_w[0]), 32'd1);
        #40;
        reset_n = 1'b0;
        #10;
        reset_n = 1'b1;
        ref_drop = 0;
        check("rstmid/oe", 32'(oe_w[0]), 32'd0);
        check("rstmid/busy", 32'(busy_w[0]), 32'd0);
        check("rstmid/leds", 32'(leds_w[0]), 32'd0);
        #HALF;
        cs[0] = 1'b1;
        #(2 * HALF);
        do_read(0, 'h10, 2, "rstmid_after");

`ifdef SPI_MEM_WP_EN
        q = {8'($urandom), 8'($urandom)};
        do_write(0, 'h20, q);
        wp_n   = 1'b0;
        wp_lvl = 1'b0;
        #HALF;
        q = {8'($urandom), 8'($urandom)};
        do_write(0, 'h20, q);
        check("wp/drop_two", 32'(drop_w[0]), 32'(ref_drop));
        do_read(0, 'h20, 2, "wp_blocked");
        wp_n   = 1'b1;
        wp_lvl = 1'b1;
        #HALF;
        q = {8'($urandom)};
        do_write(0, 'h20, q);
        check("wp/drop_kept", 32'(drop_w[0]), 32'(ref_drop));
        do_read(0, 'h20, 2, "wp_open");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
